// File: rtl/parametric_array_writer_if.sv
// Write/clear handshake and flattened read bus of the parametric array writer.
// The master side drives requests and the slave side owns the array.
interface parametric_array_writer_if #(
  parameter int mem_width = 16,
  parameter int mem_depth = 16
);
  localparam int AW = (mem_depth > 1) ? $clog2(mem_depth) : 1;

  logic                           wr_valid;
  logic                           wr_ready;
  logic [AW-1:0]                  wr_addr;
  logic [mem_width-1:0]           wr_data;
  logic [mem_width-1:0]           wr_mask;
  logic                           wr_err;
  logic                           clr_req;
  logic                           clr_busy;
  logic                           clr_done;
  logic [mem_width*mem_depth-1:0] data_flat;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, clr_req,
    input  wr_ready, wr_err, clr_busy, clr_done, data_flat
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, clr_req,
    output wr_ready, wr_err, clr_busy, clr_done, data_flat
  );
endinterface

// File: rtl/parametric_array_writer.sv
// Register array with masked single-entry writes and a one-entry-per-cycle
// bulk clear, published as a flattened bus for address-selected readers.
module parametric_array_writer #(
  parameter int                   mem_width   = 16,
  parameter int                   mem_depth   = 16,
  parameter logic [mem_width-1:0] CLEAR_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  parametric_array_writer_if.slave bus
);
  localparam int            AW    = (mem_depth > 1) ? $clog2(mem_depth) : 1;
  localparam logic [AW:0]   DEPTH = (AW+1)'(mem_depth);
  localparam logic [AW-1:0] LAST  = AW'(mem_depth - 1);
  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    CLEAR = 1'b1;

  logic [0:0]           r_state;
  logic [AW-1:0]        r_cnt;
  logic [mem_width-1:0] r_mem [mem_depth];
  logic                 r_err;
  logic                 r_done;

  logic                           w_accept;
  logic                           w_in_range;
  logic                           w_we;
  logic [mem_width*mem_depth-1:0] w_flat;

  assign bus.wr_ready  = (r_state == IDLE);
  assign bus.clr_busy  = (r_state == CLEAR);
  assign bus.wr_err    = r_err;
  assign bus.clr_done  = r_done;
  assign bus.data_flat = w_flat;

  assign w_accept   = bus.wr_valid & bus.wr_ready;
  // Extra MSB lets non-power-of-two depths flag addresses past the last entry.
  assign w_in_range = ({1'b0, bus.wr_addr} < DEPTH);
  assign w_we       = w_accept & w_in_range;

  always_comb begin
    w_flat = '0;
    for (int i = 0; i < mem_depth; i++) begin
      w_flat[i*mem_width +: mem_width] = r_mem[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < mem_depth; i++) begin
        r_mem[i] <= CLEAR_VALUE;
      end
    end else begin
      r_err  <= w_accept & ~w_in_range;
      r_done <= 1'b0;
      for (int i = 0; i < mem_depth; i++) begin
        if ((r_state == CLEAR) && (r_cnt == AW'(i))) begin
          r_mem[i] <= CLEAR_VALUE;
        end else if (w_we && (bus.wr_addr == AW'(i))) begin
          r_mem[i] <= (r_mem[i] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
        end
      end
      if (r_state == IDLE) begin
        if (bus.clr_req) begin
          r_state <= CLEAR;
          r_cnt   <= '0;
        end
      end else if (r_cnt == LAST) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_done  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_parametric_array_writer.sv
// Directed and randomized checks of parametric_array_writer at depths 16 and 12
// against a plain array model of the register bank.
module tb_parametric_array_writer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [15:0] m16 [16];
  logic [15:0] m12 [12];

  parametric_array_writer_if #(.mem_width(16), .mem_depth(16)) bus16 ();
  parametric_array_writer_if #(.mem_width(16), .mem_depth(12)) bus12 ();

  parametric_array_writer #(.mem_width(16), .mem_depth(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );
  parametric_array_writer #(.mem_width(16), .mem_depth(12)) dut12 (
    .clk(clk), .reset(reset), .bus(bus12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] flat16();
    logic [255:0] f = '0;
    for (int k = 0; k < 16; k++) f[k*16 +: 16] = m16[k];
    return f;
  endfunction

  function automatic logic [255:0] flat12();
    logic [255:0] f = '0;
    for (int k = 0; k < 12; k++) f[k*16 +: 16] = m12[k];
    return f;
  endfunction

  task automatic clear_models();
    for (int k = 0; k < 16; k++) m16[k] = '0;
    for (int k = 0; k < 12; k++) m12[k] = '0;
  endtask

  task automatic wr16(input int a, input logic [15:0] d, input logic [15:0] mk);
    bus16.wr_valid = 1'b1;
    bus16.wr_addr  = 4'(a);
    bus16.wr_data  = d;
    bus16.wr_mask  = mk;
    tick();
    m16[a] = (m16[a] & ~mk) | (d & mk);
    chkw("wr16_flat", 256'(bus16.data_flat), flat16());
    chkb("wr16_err", bus16.wr_err, 1'b0);
    bus16.wr_valid = 1'b0;
  endtask

  task automatic wr12(input int a, input logic [15:0] d, input logic [15:0] mk);
    logic exp_err;
    bus12.wr_valid = 1'b1;
    bus12.wr_addr  = 4'(a);
    bus12.wr_data  = d;
    bus12.wr_mask  = mk;
    tick();
    exp_err = (a >= 12);
    if (!exp_err) m12[a] = (m12[a] & ~mk) | (d & mk);
    chkw("wr12_flat", 256'(bus12.data_flat), flat12());
    chkb("wr12_err", bus12.wr_err, exp_err);
    chkb("wr12_ready", bus12.wr_ready, 1'b1);
    bus12.wr_valid = 1'b0;
  endtask

  initial begin
    int busy_n;
    int done_n;
    int cyc;
    logic seen_bad;
    checks   = 0;
    failures = 0;
    clear_models();
    bus16.wr_valid = 1'b0; bus16.wr_addr = '0; bus16.wr_data = '0;
    bus16.wr_mask  = '0;   bus16.clr_req = 1'b0;
    bus12.wr_valid = 1'b0; bus12.wr_addr = '0; bus12.wr_data = '0;
    bus12.wr_mask  = '0;   bus12.clr_req = 1'b0;

    // Reset state, observed before any clock edge
    reset = 1'b1;
    #1;
    chkw("rst_flat16", 256'(bus16.data_flat), 256'd0);
    chkw("rst_flat12", 256'(bus12.data_flat), 256'd0);
    chkb("rst_ready", bus16.wr_ready, 1'b1);
    chkb("rst_busy", bus16.clr_busy, 1'b0);
    chkb("rst_err", bus16.wr_err, 1'b0);
    chkb("rst_done", bus16.clr_done, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Masked writes to entry 3
    wr16(3, 16'hBEEF, 16'hFFFF);
    chkw("beef_slice", 256'(bus16.data_flat[63:48]), 256'(16'hBEEF));
    wr16(3, 16'h0000, 16'h00FF);
    chkw("be00_slice", 256'(bus16.data_flat[63:48]), 256'(16'hBE00));
    wr16(7, 16'h1234, 16'h0000);
    chkw("mask0_slice", 256'(bus16.data_flat[127:112]), 256'd0);

    // Out-of-range address on the 12-deep instance
    wr12(13, 16'h1234, 16'hFFFF);
    tick();
    chkb("oor_err_drop", bus12.wr_err, 1'b0);
    chkw("oor_flat", 256'(bus12.data_flat), 256'd0);
    for (int n = 0; n < 24; n++) begin
      wr12($urandom_range(0, 15), 16'($urandom), (n % 5 == 0) ? 16'h0 : 16'($urandom));
    end

    // Random masked writes on the 16-deep instance
    for (int n = 0; n < 40; n++) begin
      wr16($urandom_range(0, 15), 16'($urandom), (n % 7 == 0) ? 16'h0 : 16'($urandom));
    end

    // Fill with A5A5, then a one-cycle clear pulse
    for (int k = 0; k < 16; k++) wr16(k, 16'hA5A5, 16'hFFFF);
    bus16.clr_req = 1'b1;
    tick();
    bus16.clr_req = 1'b0;
    busy_n = 0;
    cyc = 0;
    while (bus16.clr_busy && cyc < 40) begin
      busy_n++;
      for (int k = 0; k < busy_n - 1 && k < 16; k++) m16[k] = '0;
      chkb("clr_ready_low", bus16.wr_ready, 1'b0);
      chkw("clr_progress", 256'(bus16.data_flat), flat16());
      chkb("clr_no_early_done", bus16.clr_done, 1'b0);
      tick();
      cyc++;
    end
    chkw("clr_busy_cycles", 256'(busy_n), 256'd16);
    chkb("clr_done_pulse", bus16.clr_done, 1'b1);
    chkw("clr_final_flat", 256'(bus16.data_flat), 256'd0);
    clear_models();
    tick();
    chkb("clr_done_drop", bus16.clr_done, 1'b0);

    // Write and clear on the same edge; second write held through the clear
    bus16.wr_valid = 1'b1; bus16.wr_addr = 4'd0;
    bus16.wr_data = 16'h7777; bus16.wr_mask = 16'hFFFF;
    bus16.clr_req = 1'b1;
    tick();
    chkw("same_edge_e0", 256'(bus16.data_flat[15:0]), 256'(16'h7777));
    chkb("same_edge_busy", bus16.clr_busy, 1'b1);
    bus16.clr_req = 1'b0;
    bus16.wr_addr = 4'd2; bus16.wr_data = 16'h2222;
    tick();
    chkw("same_edge_e0_cleared", 256'(bus16.data_flat[15:0]), 256'd0);
    cyc = 0;
    while (bus16.clr_busy && cyc < 40) begin
      chkw("held_not_written", 256'(bus16.data_flat[47:32]), 256'd0);
      tick();
      cyc++;
    end
    chkb("held_done", bus16.clr_done, 1'b1);
    chkb("held_ready", bus16.wr_ready, 1'b1);
    tick();
    m16[2] = 16'h2222;
    chkw("held_accepted", 256'(bus16.data_flat), flat16());
    bus16.wr_valid = 1'b0;

    // clr_req held high restarts a clear in the clr_done cycle
    bus16.clr_req = 1'b1;
    tick();
    cyc = 0;
    while (!bus16.clr_done && cyc < 40) begin
      tick();
      cyc++;
    end
    chkb("rep_done_seen", bus16.clr_done, 1'b1);
    tick();
    chkb("rep_restart", bus16.clr_busy, 1'b1);
    bus16.clr_req = 1'b0;
    cyc = 0;
    done_n = 0;
    while (cyc < 40) begin
      if (bus16.clr_done) done_n++;
      tick();
      cyc++;
    end
    chkw("rep_second_done", 256'(done_n), 256'd1);
    clear_models();

    // Reset asserted asynchronously in clear cycle 5
    for (int k = 0; k < 5; k++) wr16(k, 16'($urandom), 16'hFFFF);
    for (int k = 5; k < 16; k++) wr16(k, 16'hFFFF, 16'hFFFF);
    bus16.clr_req = 1'b1;
    tick();
    bus16.clr_req = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 5; k++) m16[k] = '0;
    chkw("mid_clear_flat", 256'(bus16.data_flat), flat16());
    #2;
    reset = 1'b1;
    #1;
    clear_models();
    chkw("async_rst_flat16", 256'(bus16.data_flat), 256'd0);
    chkw("async_rst_flat12", 256'(bus12.data_flat), 256'd0);
    chkb("async_rst_busy", bus16.clr_busy, 1'b0);
    chkb("async_rst_ready", bus16.wr_ready, 1'b1);
    chkb("async_rst_done", bus16.clr_done, 1'b0);
    tick();
    reset = 1'b0;
    seen_bad = 1'b0;
    repeat (20) begin
      tick();
      if (bus16.clr_done || bus16.clr_busy) seen_bad = 1'b1;
    end
    chkb("no_done_after_rst", seen_bad, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
